mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between two requesters: the instruction-fetch path and the load/store data path.
- Accepts at most one transaction at a time and drives the memory address, write-data and write-enable.
- Waits the memory's fixed read latency, then returns the read data or a write acknowledge to the requester that owned the transaction.
- Sits between fetch / control FSM and the memory array; replaces the ad-hoc address-source mux in front of memory.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data word width
MEM_LATENCY, 1, cycles from accept edge to valid memory read data (legal 1..7)
DATA_PRIORITY, 0, 0 = round-robin between requesters; 1 = data requester always wins ties

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_req_valid  in  1  fetch request valid
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_WIDTH  fetch address
i_rsp_valid  out  1  fetch response valid, 1-cycle pulse
i_rsp_data  out  DATA_WIDTH  fetched instruction word
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  ADDR_WIDTH  data address
d_req_we  in  1  1 = store, 0 = load
d_req_wdata  in  DATA_WIDTH  store data
d_rsp_valid  out  1  data response/ack valid, 1-cycle pulse
d_rsp_data  out  DATA_WIDTH  load data; 0 for store acks
mem_a  out  ADDR_WIDTH  memory address
mem_wd  out  DATA_WIDTH  memory write data
mem_we  out  1  memory write enable
mem_rd  in  DATA_WIDTH  memory read data (synchronous read)
busy  out  1  transaction outstanding
grant_owner  out  1  0 = fetch, 1 = data; owner of last accepted transaction

Behaviour:
- Reset (reset = 0, async): state IDLE; all ready/rsp_valid/mem_we = 0; mem_a = 0; mem_wd = 0; rsp_data = 0; busy = 0; grant_owner = 0; last-grant pointer = data, so fetch wins the first tie after reset.
- States:
  - IDLE: no transaction outstanding.
  - WAIT: latency counter running.
  - RESP: response pulse cycle.
- Acceptance is allowed in IDLE and RESP only. In an accept cycle T:
  - Exactly one x_req_ready = 1, combinationally from the valids.
  - mem_a, mem_wd and mem_we are driven combinationally from the winner; mem_we = d_req_we only when data wins, else 0.
  - Winner's address, owner and we are registered.
- Selection:
  - One valid: it wins.
  - Both valid, DATA_PRIORITY = 1: data wins.
  - Both valid, DATA_PRIORITY = 0: the requester not granted last wins. The pointer updates only on accept.
- Outside accept cycles: mem_a holds the last accepted address, mem_we = 0, mem_wd holds its last value.
- Latency:
  - After accept at T, the response is in cycle T+MEM_LATENCY.
  - MEM_LATENCY = 1: go directly to RESP.
  - Otherwise: WAIT with 3-bit counter loaded with MEM_LATENCY-1, decrement per cycle, enter RESP when it reaches 1.
- RESP cycle:
  - Owner's rsp_valid = 1 for exactly one cycle; rsp_data = mem_rd for loads/fetches, 0 for stores.
  - The non-owner's rsp_valid stays 0; its rsp_data holds its previous value.
  - A new request may be accepted in the same RESP cycle. Next state is RESP/WAIT if accepted, else IDLE.
  - Peak throughput is one transaction per MEM_LATENCY cycles.
- No response backpressure: requesters must sink rsp_valid when it arrives.
- Request rules:
  - Requesters hold valid, addr, we and wdata stable until ready.
  - The arbiter never drops a pending valid; the loser keeps valid and is served next.
  - Under round-robin with both always valid, grants alternate strictly.
- busy = (state != IDLE).
- Reset asserted mid-WAIT/RESP: the transaction is abandoned; no rsp_valid is emitted after reset deasserts. A store already written at its accept edge stays written.
- Address/data are passed unmodified; no alignment checks.

Decomposition:
- Shared package types.svh:
  - mem_owner_t enum with MEM_OWNER__FETCH = 0 and MEM_OWNER__DATA = 1.
  - mem_arb_state_t enum with MEM_ARB__IDLE, MEM_ARB__WAIT and MEM_ARB__RESP.
- One natural sub-module, mem_arb_pick: a combinational two-way pick from the two valids, DATA_PRIORITY and the last-grant pointer, producing the winner and the grant one-hot. The FSM, counter and registers stay in the top.

Test Plan:
- Reset release, then i_req_valid = 1 with addr 0x0000_0010 and memory word 0xDEAD_BEEF; MEM_LATENCY = 1 → i_req_ready = 1 at T, i_rsp_valid = 1 with i_rsp_data = 0xDEAD_BEEF at T+1, d_rsp_valid = 0 throughout.
- Store: d_req_we = 1, addr 0x40, wdata 0x1234_5678 → mem_we = 1 for exactly one cycle, d_rsp_valid at T+1 with data 0; a following load from 0x40 returns 0x1234_5678.
- Both valid continuously, DATA_PRIORITY = 0, 4 transactions → grant order fetch, data, fetch, data; a new accept occurs in each RESP cycle, with one response per cycle.
- DATA_PRIORITY = 1, both valid for 3 transactions → data granted 3 times, i_req_ready stays 0, and fetch is granted on the 4th once d_req_valid drops.
- MEM_LATENCY = 3: accept at T → no ready in T+1 and T+2; rsp_valid at T+3 with mem_rd sampled in T+3; busy = 1 from T+1 through T+3.
- Assert reset during WAIT (MEM_LATENCY = 3, reset at T+1) → all outputs at their reset values immediately; no rsp_valid in any cycle after release until a new accept.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory-port arbiter: requester identity and FSM states.
package mem_port_arbiter_pkg;

    typedef enum logic {
        MEM_OWNER__FETCH = 1'b0,
        MEM_OWNER__DATA  = 1'b1
    } mem_owner_t;

    typedef enum logic [1:0] {
        MEM_ARB__IDLE = 2'd0,
        MEM_ARB__WAIT = 2'd1,
        MEM_ARB__RESP = 2'd2
    } mem_arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way pick between fetch and data requesters.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_PRIORITY = 0
) (
    input  logic       i_valid,
    input  logic       d_valid,
    input  mem_owner_t last_owner,
    output mem_owner_t winner,
    output logic [1:0] grant
);

    always_comb begin
        winner = MEM_OWNER__FETCH;
        if (i_valid && d_valid) begin
            // On a tie the requester that did not win last time goes next.
            winner = ((DATA_PRIORITY != 0) || (last_owner == MEM_OWNER__FETCH))
                     ? MEM_OWNER__DATA : MEM_OWNER__FETCH;
        end else if (d_valid) begin
            winner = MEM_OWNER__DATA;
        end

        grant = 2'b00;
        if (i_valid || d_valid) begin
            grant = (winner == MEM_OWNER__DATA) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and load/store,
// one transaction in flight, response returned MEM_LATENCY cycles after accept.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 1,
    parameter int DATA_PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  i_rsp_valid,
    output logic [DATA_WIDTH-1:0] i_rsp_data,
    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic                  d_req_we,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_rsp_valid,
    output logic [DATA_WIDTH-1:0] d_rsp_data,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy,
    output logic                  grant_owner
);

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LATENCY - 1);

    mem_arb_state_t        state_p0, state_nxt;
    logic [2:0]            cnt_p0;
    mem_owner_t            owner_p0, last_p0, winner;
    logic                  we_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [DATA_WIDTH-1:0] wd_p0, i_data_p0, d_data_p0, rsp_word;
    logic [1:0]            grant;
    logic                  can_accept, accept, win_data;

    mem_arb_pick #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick (
        .i_valid    (i_req_valid),
        .d_valid    (d_req_valid),
        .last_owner (last_p0),
        .winner     (winner),
        .grant      (grant)
    );

    // Gating with reset keeps every ready and mem_we low while reset is held.
    assign can_accept = reset && ((state_p0 == MEM_ARB__IDLE) || (state_p0 == MEM_ARB__RESP));
    assign accept     = can_accept && (grant != 2'b00);
    assign win_data   = (winner == MEM_OWNER__DATA);

    always_comb begin
        state_nxt = state_p0;
        unique case (state_p0)
            MEM_ARB__IDLE, MEM_ARB__RESP:
                state_nxt = accept ? ((MEM_LATENCY == 1) ? MEM_ARB__RESP : MEM_ARB__WAIT)
                                   : MEM_ARB__IDLE;
            MEM_ARB__WAIT:
                if (cnt_p0 == 3'd1) state_nxt = MEM_ARB__RESP;
            default:
                state_nxt = MEM_ARB__IDLE;
        endcase
    end

    // Stage p0: FSM state, latency counter and the accepted transaction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_p0  <= MEM_ARB__IDLE;
            cnt_p0    <= 3'd0;
            owner_p0  <= MEM_OWNER__FETCH;
            last_p0   <= MEM_OWNER__DATA;
            we_p0     <= 1'b0;
            addr_p0   <= '0;
            wd_p0     <= '0;
            i_data_p0 <= '0;
            d_data_p0 <= '0;
        end else begin
            state_p0 <= state_nxt;
            if (accept) begin
                cnt_p0   <= CNT_LOAD;
                owner_p0 <= winner;
                last_p0  <= winner;
                we_p0    <= win_data && d_req_we;
                addr_p0  <= win_data ? d_req_addr : i_req_addr;
                if (win_data) wd_p0 <= d_req_wdata;
            end else if (state_p0 == MEM_ARB__WAIT) begin
                cnt_p0 <= cnt_p0 - 3'd1;
            end
            if (state_p0 == MEM_ARB__RESP) begin
                if (owner_p0 == MEM_OWNER__FETCH) i_data_p0 <= rsp_word;
                else                              d_data_p0 <= rsp_word;
            end
        end
    end

    always_comb begin
        rsp_word    = we_p0 ? '0 : mem_rd;
        i_req_ready = can_accept && grant[0];
        d_req_ready = can_accept && grant[1];
        i_rsp_valid = (state_p0 == MEM_ARB__RESP) && (owner_p0 == MEM_OWNER__FETCH);
        d_rsp_valid = (state_p0 == MEM_ARB__RESP) && (owner_p0 == MEM_OWNER__DATA);
        i_rsp_data  = i_rsp_valid ? rsp_word : i_data_p0;
        d_rsp_data  = d_rsp_valid ? rsp_word : d_data_p0;
        mem_a       = accept ? (win_data ? d_req_addr : i_req_addr) : addr_p0;
        mem_wd      = (accept && win_data) ? d_req_wdata : wd_p0;
        mem_we      = accept && win_data && d_req_we;
        busy        = (state_p0 != MEM_ARB__IDLE);
        grant_owner = owner_p0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter instances (round-robin/lat1, data-priority/lat1,
// round-robin/lat3) share the request inputs, each with its own memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_req_valid, d_req_valid, d_req_we;
    logic [31:0] i_req_addr, d_req_addr, d_req_wdata;

    logic        i_req_ready [3];
    logic        i_rsp_valid [3];
    logic [31:0] i_rsp_data  [3];
    logic        d_req_ready [3];
    logic        d_rsp_valid [3];
    logic [31:0] d_rsp_data  [3];
    logic [31:0] mem_a       [3];
    logic [31:0] mem_wd      [3];
    logic        mem_we      [3];
    logic        busy        [3];
    logic        grant_owner [3];

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem [256];
        logic [31:0] rd;

        mem_port_arbiter #(
            .ADDR_WIDTH    (32),
            .DATA_WIDTH    (32),
            .MEM_LATENCY   ((g == 2) ? 3 : 1),
            .DATA_PRIORITY ((g == 1) ? 1 : 0)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .i_req_valid (i_req_valid),
            .i_req_ready (i_req_ready[g]),
            .i_req_addr  (i_req_addr),
            .i_rsp_valid (i_rsp_valid[g]),
            .i_rsp_data  (i_rsp_data[g]),
            .d_req_valid (d_req_valid),
            .d_req_ready (d_req_ready[g]),
            .d_req_addr  (d_req_addr),
            .d_req_we    (d_req_we),
            .d_req_wdata (d_req_wdata),
            .d_rsp_valid (d_rsp_valid[g]),
            .d_rsp_data  (d_rsp_data[g]),
            .mem_a       (mem_a[g]),
            .mem_wd      (mem_wd[g]),
            .mem_we      (mem_we[g]),
            .mem_rd      (rd),
            .busy        (busy[g]),
            .grant_owner (grant_owner[g])
        );

        // Synchronous-read memory; word 0x10 is preloaded while reset is held.
        always_ff @(posedge clk) begin
            if (!reset)          mem[4] <= 32'hDEAD_BEEF;
            else if (mem_we[g])  mem[mem_a[g][9:2]] <= mem_wd[g];
            rd <= mem[mem_a[g][9:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10;
        d_req_valid = 1'b0;
        d_req_we    = 1'b0;
        d_req_addr  = 32'h0;
        d_req_wdata = 32'h0;
        #2;
        chk("rst_i_ready", i_req_ready[0], 1'b0);
        chk("rst_busy", busy[0], 1'b0);
        chk("rst_mem_a", mem_a[0], 32'h0);
        chk("rst_mem_we", mem_we[0], 1'b0);
        chk("rst_owner", grant_owner[0], 1'b0);
        chk("rst_i_rsp_valid", i_rsp_valid[0], 1'b0);
        chk("rst_d_rsp_data", d_rsp_data[0], 32'h0);
        repeat (2) @(posedge clk);
        cyc();
        reset       = 1'b1;
        i_req_valid = 1'b0;

        // Fetch from 0x10, latency 1.
        cyc(); i_req_valid = 1'b1; i_req_addr = 32'h10; #1;
        chk("f_i_ready", i_req_ready[0], 1'b1);
        chk("f_mem_a", mem_a[0], 32'h10);
        chk("f_d_rsp_t", d_rsp_valid[0], 1'b0);
        cyc(); i_req_valid = 1'b0; #1;
        chk("f_i_rsp_valid", i_rsp_valid[0], 1'b1);
        chk("f_i_rsp_data", i_rsp_data[0], 32'hDEAD_BEEF);
        chk("f_d_rsp_t1", d_rsp_valid[0], 1'b0);
        chk("f_busy", busy[0], 1'b1);
        cyc(); #1;
        chk("f_i_rsp_drop", i_rsp_valid[0], 1'b0);
        chk("f_idle", busy[0], 1'b0);
        chk("f_data_hold", i_rsp_data[0], 32'hDEAD_BEEF);
        chk("f_addr_hold", mem_a[0], 32'h10);

        // Store 0x1234_5678 to 0x40, then load it back.
        cyc(); d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h40; d_req_wdata = 32'h1234_5678; #1;
        chk("st_d_ready", d_req_ready[0], 1'b1);
        chk("st_i_ready", i_req_ready[0], 1'b0);
        chk("st_mem_we", mem_we[0], 1'b1);
        chk("st_mem_wd", mem_wd[0], 32'h1234_5678);
        chk("st_mem_a", mem_a[0], 32'h40);
        cyc(); d_req_valid = 1'b0; d_req_we = 1'b0; #1;
        chk("st_mem_we_drop", mem_we[0], 1'b0);
        chk("st_ack_valid", d_rsp_valid[0], 1'b1);
        chk("st_ack_data", d_rsp_data[0], 32'h0);
        chk("st_i_rsp", i_rsp_valid[0], 1'b0);
        chk("st_wd_hold", mem_wd[0], 32'h1234_5678);
        cyc(); d_req_valid = 1'b1; #1;
        chk("ld_d_ready", d_req_ready[0], 1'b1);
        chk("ld_mem_we", mem_we[0], 1'b0);
        cyc(); d_req_valid = 1'b0; #1;
        chk("ld_rsp_valid", d_rsp_valid[0], 1'b1);
        chk("ld_rsp_data", d_rsp_data[0], 32'h1234_5678);

        // Round-robin with both requesters continuously valid.
        pulse_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_addr = 32'h40; d_req_we = 1'b0; #1;
        chk("rr0_i_ready", i_req_ready[0], 1'b1);
        chk("rr0_d_ready", d_req_ready[0], 1'b0);
        chk("rr0_owner", grant_owner[0], 1'b0);
        cyc(); #1;
        chk("rr1_i_rsp", i_rsp_valid[0], 1'b1);
        chk("rr1_d_ready", d_req_ready[0], 1'b1);
        chk("rr1_i_ready", i_req_ready[0], 1'b0);
        chk("rr1_owner", grant_owner[0], 1'b0);
        cyc(); #1;
        chk("rr2_d_rsp", d_rsp_valid[0], 1'b1);
        chk("rr2_d_data", d_rsp_data[0], 32'h1234_5678);
        chk("rr2_i_ready", i_req_ready[0], 1'b1);
        chk("rr2_i_rsp", i_rsp_valid[0], 1'b0);
        chk("rr2_owner", grant_owner[0], 1'b1);
        cyc(); #1;
        chk("rr3_i_rsp", i_rsp_valid[0], 1'b1);
        chk("rr3_i_data", i_rsp_data[0], 32'hDEAD_BEEF);
        chk("rr3_d_ready", d_req_ready[0], 1'b1);
        chk("rr3_owner", grant_owner[0], 1'b0);
        cyc(); i_req_valid = 1'b0; d_req_valid = 1'b0; #1;
        chk("rr4_d_rsp", d_rsp_valid[0], 1'b1);
        chk("rr4_i_ready", i_req_ready[0], 1'b0);
        chk("rr4_d_ready", d_req_ready[0], 1'b0);
        chk("rr4_owner", grant_owner[0], 1'b1);
        cyc(); #1;
        chk("rr5_idle", busy[0], 1'b0);

        // Data priority: data wins every tie until it drops.
        pulse_reset();
        i_req_valid = 1'b1; d_req_valid = 1'b1; #1;
        chk("dp0_d_ready", d_req_ready[1], 1'b1);
        chk("dp0_i_ready", i_req_ready[1], 1'b0);
        for (int k = 1; k <= 2; k++) begin
            cyc(); #1;
            chk($sformatf("dp%0d_d_ready", k), d_req_ready[1], 1'b1);
            chk($sformatf("dp%0d_i_ready", k), i_req_ready[1], 1'b0);
            chk($sformatf("dp%0d_d_rsp", k), d_rsp_valid[1], 1'b1);
        end
        cyc(); d_req_valid = 1'b0; #1;
        chk("dp3_i_ready", i_req_ready[1], 1'b1);
        chk("dp3_d_rsp", d_rsp_valid[1], 1'b1);
        chk("dp3_owner", grant_owner[1], 1'b1);
        cyc(); i_req_valid = 1'b0; #1;
        chk("dp4_i_rsp", i_rsp_valid[1], 1'b1);
        chk("dp4_i_data", i_rsp_data[1], 32'hDEAD_BEEF);
        chk("dp4_owner", grant_owner[1], 1'b0);

        // Latency 3 with a back-to-back fetch accepted in the response cycle.
        pulse_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h10; #1;
        chk("l3_t0_ready", i_req_ready[2], 1'b1);
        chk("l3_t0_busy", busy[2], 1'b0);
        for (int k = 1; k <= 2; k++) begin
            cyc(); #1;
            chk($sformatf("l3_t%0d_ready", k), i_req_ready[2], 1'b0);
            chk($sformatf("l3_t%0d_busy", k), busy[2], 1'b1);
            chk($sformatf("l3_t%0d_rsp", k), i_rsp_valid[2], 1'b0);
        end
        cyc(); #1;
        chk("l3_t3_rsp", i_rsp_valid[2], 1'b1);
        chk("l3_t3_data", i_rsp_data[2], 32'hDEAD_BEEF);
        chk("l3_t3_busy", busy[2], 1'b1);
        chk("l3_t3_ready", i_req_ready[2], 1'b1);
        cyc(); i_req_valid = 1'b0; #1;
        chk("l3_t4_rsp", i_rsp_valid[2], 1'b0);
        chk("l3_t4_busy", busy[2], 1'b1);
        cyc(); #1;
        chk("l3_t5_rsp", i_rsp_valid[2], 1'b0);
        cyc(); #1;
        chk("l3_t6_rsp", i_rsp_valid[2], 1'b1);
        chk("l3_t6_data", i_rsp_data[2], 32'hDEAD_BEEF);
        cyc(); #1;
        chk("l3_t7_idle", busy[2], 1'b0);

        // Reset asserted while waiting abandons the transaction.
        pulse_reset();
        i_req_valid = 1'b1; i_req_addr = 32'h10; #1;
        chk("ra_ready", i_req_ready[2], 1'b1);
        cyc(); #1;
        chk("ra_wait_busy", busy[2], 1'b1);
        chk("ra_wait_ready", i_req_ready[2], 1'b0);
        reset = 1'b0; #1;
        chk("ra_busy", busy[2], 1'b0);
        chk("ra_ready_held", i_req_ready[2], 1'b0);
        chk("ra_rsp", i_rsp_valid[2], 1'b0);
        chk("ra_mem_a", mem_a[2], 32'h0);
        chk("ra_owner", grant_owner[2], 1'b0);
        i_req_valid = 1'b0;
        cyc(); reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk($sformatf("ra_post%0d_rsp", k), i_rsp_valid[2], 1'b0);
            chk($sformatf("ra_post%0d_busy", k), busy[2], 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
